// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/commit controller feeding a combinational MIPS ALU.
// Accepts one instruction per valid/ready handshake, reads rs/rt from a 32x32
// register file, presents them to the ALU, then commits the result as a
// register write, branch decision, memory request or error pulse.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   in_valid/in_ready/in_instr   instruction handshake (ready = idle)
//   alu_instruction/regA/regB    registered ALU operands
//   alu_result/alu_flag          ALU response, flag = {ovf, neg, zero}
//   wb_*                         register write pulse, address, data
//   br_*                         branch resolved pulse, decision, offset
//   mem_*                        lw/sw request pulse, write enable, address, data
//   ovf, err                     overflow trap pulse, unsupported instruction pulse
//   dbg_addr/dbg_data            combinational register file read port
// Build option: ALU_ISSUE_OVF_TRAP_EN makes add/addi/sub overflow suppress the
// write and pulse ovf; without it overflow is ignored and ovf is tied low.
module alu_issue_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic [31:0] alu_instruction,
   output logic [31:0] alu_regA,
   output logic [31:0] alu_regB,
   input  logic [31:0] alu_result,
   input  logic [2:0]  alu_flag,
   output logic        wb_valid,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        br_valid,
   output logic        br_taken,
   output logic [15:0] br_offset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        ovf,
   output logic        err,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COMMIT} state_t;
   state_t      r_state, w_next;
   logic [31:0] r_rf [32];
   logic [31:0] r_instr, r_rega, r_regb, r_wb_data, r_mem_addr, r_mem_wdata;
   logic [15:0] r_br_offset;
   logic [4:0]  r_wb_addr;
   logic        r_wb_valid, r_br_valid, r_br_taken, r_mem_req, r_mem_we, r_err;
   logic [5:0]  w_op, w_fn;
   logic [4:0]  w_dest;
   logic        w_rtype, w_itype, w_br, w_mem, w_trap, w_wr, w_err;
   logic        w_unused;
   assign w_op    = r_instr[31:26];
   assign w_fn    = r_instr[5:0];
   assign w_rtype = (w_op == 6'h00) && (w_fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                                     [6'h20:6'h27], 6'h2A, 6'h2B});
   assign w_itype = w_op inside {[6'h08:6'h0E]};
   assign w_br    = w_op inside {6'h04, 6'h05};
   assign w_mem   = w_op inside {6'h23, 6'h2B};
   assign w_dest  = w_rtype ? r_instr[15:11] : r_instr[20:16];
`ifdef ALU_ISSUE_OVF_TRAP_EN
   logic r_ovf;
   assign w_trap   = ((w_op == 6'h00 && (w_fn == 6'h20 || w_fn == 6'h22)) || w_op == 6'h08) && alu_flag[2];
   assign ovf      = r_ovf;
   assign w_unused = alu_flag[1];
`else
   assign w_trap   = 1'b0;
   assign ovf      = 1'b0;
   assign w_unused = ^alu_flag[2:1];
`endif
   // r0 is never a write target, so a zero dest simply drops the write
   assign w_wr  = (w_rtype | w_itype) & ~w_trap & (w_dest != 5'd0);
   assign w_err = ~(w_rtype | w_itype | w_br | w_mem);
   always_comb begin
      w_next = r_state;
      w_next = (r_state == S_IDLE)  ? (in_valid ? S_ISSUE : S_IDLE) :
               (r_state == S_ISSUE) ? S_COMMIT : S_IDLE;
   end
   // Commit outputs are registered at the end of ISSUE, which is where the
   // ALU result and flags are latched; pulses therefore live only in COMMIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         for (int i = 0; i < 32; i++) r_rf[i] <= '0;
         r_instr     <= '0;
         r_rega      <= '0;
         r_regb      <= '0;
         r_wb_valid  <= 1'b0;
         r_wb_addr   <= '0;
         r_wb_data   <= '0;
         r_br_valid  <= 1'b0;
         r_br_taken  <= 1'b0;
         r_br_offset <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_err       <= 1'b0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
         r_ovf       <= 1'b0;
`endif
      end else begin
         r_state    <= w_next;
         r_wb_valid <= 1'b0;
         r_br_valid <= 1'b0;
         r_mem_req  <= 1'b0;
         r_err      <= 1'b0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
         r_ovf      <= 1'b0;
`endif
         if (r_state == S_IDLE && in_valid) begin
            r_instr <= in_instr;
            r_rega  <= r_rf[in_instr[25:21]];
            r_regb  <= r_rf[in_instr[20:16]];
         end
         if (r_state == S_ISSUE) begin
            r_wb_valid <= w_wr;
            r_br_valid <= w_br;
            r_mem_req  <= w_mem;
            r_err      <= w_err;
`ifdef ALU_ISSUE_OVF_TRAP_EN
            r_ovf      <= w_trap;
`endif
            if (w_wr) begin
               r_wb_addr <= w_dest;
               r_wb_data <= alu_result;
            end
            if (w_br) begin
               r_br_taken  <= (w_op == 6'h05) ^ alu_flag[0];
               r_br_offset <= r_instr[15:0];
            end
            if (w_mem) begin
               r_mem_we    <= (w_op == 6'h2B);
               r_mem_addr  <= alu_result;
               r_mem_wdata <= r_regb;
            end
         end
         if (r_state == S_COMMIT && r_wb_valid) r_rf[r_wb_addr] <= r_wb_data;
      end
   end
   assign in_ready        = (r_state == S_IDLE);
   assign alu_instruction = r_instr;
   assign alu_regA        = r_rega;
   assign alu_regB        = r_regb;
   assign wb_valid        = r_wb_valid;
   assign wb_addr         = r_wb_addr;
   assign wb_data         = r_wb_data;
   assign br_valid        = r_br_valid;
   assign br_taken        = r_br_taken;
   assign br_offset       = r_br_offset;
   assign mem_req         = r_mem_req;
   assign mem_we          = r_mem_we;
   assign mem_addr        = r_mem_addr;
   assign mem_wdata       = r_mem_wdata;
   assign err             = r_err;
   assign dbg_data        = (dbg_addr == 5'd0) ? 32'd0 : r_rf[dbg_addr];
endmodule
